// File: rtl/hd63701_phase_seq.sv
// ---------------------------------------------------------------------------
// hd63701_phase_seq
//
// Phase sequencer for an HD63701-style CPU core. It walks the reset vector
// fetch, opcode fetch, the microcoded execute phases and the interrupt entry
// sequence. It also arbitrates between pending NMI, IRQ, WAI sleep and the
// next opcode fetch at each end of instruction.
//
// Optional feature macro: HD63701_SLEEP_EN
//   defined   : MC_WAI at end of instruction parks the core in SLEEP until
//               an interrupt arrives.
//   undefined : MC_WAI is ignored and SLEEP is never entered.
//
// Ports
//   clk      in   core clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   clock enable; state advances only on enabled edges
//   mc_end   in   microcode end-of-instruction flag (EXEC phases)
//   mc_wai   in   microcode wait-for-interrupt request, qualified by mc_end
//   nmi      in   non-maskable interrupt, rising-edge sensitive
//   irq      in   maskable interrupt, level sensitive
//   imask    in   CCR I flag; 1 blocks irq
//   phase    out  [5:0] current phase code (microcode ROM phase select)
//   vsel     out  [1:0] vector select: 0 reset, 1 NMI, 2 IRQ
//   opc_ld   out  opcode-load strobe, high while phase=FETCH and en=1
//   int_ack  out  one-cycle interrupt-accept pulse after entering INTR0
//   halted   out  high while in HALT
// ---------------------------------------------------------------------------
module hd63701_phase_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       mc_end,
    input  logic       mc_wai,
    input  logic       nmi,
    input  logic       irq,
    input  logic       imask,
    output logic [5:0] phase,
    output logic [1:0] vsel,
    output logic       opc_ld,
    output logic       int_ack,
    output logic       halted
);

    typedef enum logic [5:0] {
        PH_RST   = 6'd0,
        PH_VECT  = 6'd1,
        PH_VEC1  = 6'd2,
        PH_VEC2  = 6'd3,
        PH_FETCH = 6'd4,
        PH_SLEEP = 6'd5,
        PH_EXEC0 = 6'd16,
        PH_EXEC1 = 6'd17,
        PH_EXEC2 = 6'd18,
        PH_EXEC3 = 6'd19,
        PH_EXEC4 = 6'd20,
        PH_EXEC5 = 6'd21,
        PH_EXEC6 = 6'd22,
        PH_EXEC7 = 6'd23,
        PH_EXEC8 = 6'd24,
        PH_EXEC9 = 6'd25,
        PH_INTR0 = 6'd32,
        PH_INTR1 = 6'd33,
        PH_INTR2 = 6'd34,
        PH_INTR3 = 6'd35,
        PH_INTR4 = 6'd36,
        PH_INTR5 = 6'd37,
        PH_INTR6 = 6'd38,
        PH_INTR7 = 6'd39,
        PH_INTR8 = 6'd40,
        PH_INTR9 = 6'd41,
        PH_HALT  = 6'd63
    } phase_t;

    typedef enum logic [1:0] {
        VEC_RESET = 2'd0,
        VEC_NMI   = 2'd1,
        VEC_IRQ   = 2'd2
    } vec_t;

    phase_t phase_q, phase_d;
    vec_t   vsel_q, vsel_d;
    logic   enter_intr;
    logic   int_ack_q;
    logic   nmi_prev;
    logic   nmi_pend;
    logic   nmi_rise;
    logic   irq_req;
    logic   int_take;
    vec_t   int_vec;

    assign nmi_rise = nmi & ~nmi_prev;
    assign irq_req  = irq & ~imask;

    // A pending NMI always outranks a maskable IRQ.
    assign int_take = nmi_pend | irq_req;
    assign int_vec  = nmi_pend ? VEC_NMI : VEC_IRQ;

`ifndef HD63701_SLEEP_EN
    // WAI has no effect in this build; the input is intentionally unused.
    logic unused_wai;
    assign unused_wai = mc_wai;
`endif

    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        phase_d    = phase_q;
        vsel_d     = vsel_q;
        enter_intr = 1'b0;

        case (phase_q)
            PH_RST:   phase_d = PH_VECT;
            PH_VECT:  phase_d = PH_VEC1;
            PH_VEC1:  phase_d = PH_VEC2;
            PH_VEC2:  phase_d = PH_FETCH;
            PH_FETCH: phase_d = PH_EXEC0;

            PH_EXEC0, PH_EXEC1, PH_EXEC2, PH_EXEC3, PH_EXEC4,
            PH_EXEC5, PH_EXEC6, PH_EXEC7, PH_EXEC8, PH_EXEC9: begin
                if (!mc_end) begin
                    // Running past the last execute slot means the microcode
                    // never terminated the instruction: lock up in HALT.
                    if (phase_q == PH_EXEC9) begin
                        phase_d = PH_HALT;
                    end else begin
                        phase_d = phase_t'(phase_q + 6'd1);
                    end
                end else if (int_take) begin
                    phase_d    = PH_INTR0;
                    vsel_d     = int_vec;
                    enter_intr = 1'b1;
                end
`ifdef HD63701_SLEEP_EN
                else if (mc_wai) begin
                    phase_d = PH_SLEEP;
                end
`endif
                else begin
                    phase_d = PH_FETCH;
                end
            end

`ifdef HD63701_SLEEP_EN
            PH_SLEEP: begin
                if (int_take) begin
                    phase_d    = PH_INTR0;
                    vsel_d     = int_vec;
                    enter_intr = 1'b1;
                end
            end
`endif

            PH_INTR0, PH_INTR1, PH_INTR2, PH_INTR3, PH_INTR4,
            PH_INTR5, PH_INTR6, PH_INTR7, PH_INTR8: begin
                phase_d = phase_t'(phase_q + 6'd1);
            end

            // The interrupt sequence finishes by fetching its vector through
            // the same VECT..VEC2 path used after reset.
            PH_INTR9: phase_d = PH_VECT;

            PH_HALT:  phase_d = PH_HALT;

            // Unused encodings recover through the reset sequence.
            default:  phase_d = PH_RST;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= PH_RST;
            vsel_q    <= VEC_RESET;
            int_ack_q <= 1'b0;
            nmi_prev  <= 1'b0;
            nmi_pend  <= 1'b0;
        end else begin
            // NMI edge detection runs on every clock, not just enabled ones,
            // so a short pulse is never missed while the core is stalled.
            nmi_prev  <= nmi;
            int_ack_q <= en & enter_intr;

            // A fresh edge takes precedence over the clear, so an NMI that
            // arrives while the previous one is being accepted is kept.
            if (nmi_rise) begin
                nmi_pend <= 1'b1;
            end else if (en && enter_intr && vsel_d == VEC_NMI) begin
                nmi_pend <= 1'b0;
            end

            if (en) begin
                phase_q <= phase_d;
                vsel_q  <= vsel_d;
            end
        end
    end

    assign phase   = phase_q;
    assign vsel    = vsel_q;
    assign opc_ld  = en & (phase_q == PH_FETCH);
    assign int_ack = en & int_ack_q;
    assign halted  = (phase_q == PH_HALT);

endmodule

// File: tb/tb_hd63701_phase_seq.sv
// ---------------------------------------------------------------------------
// tb_hd63701_phase_seq
//
// Self-checking bench for hd63701_phase_seq. Each scenario task builds a
// table of steps (inputs to drive before an edge plus the outputs expected
// after it). Expected outputs are pushed to a scoreboard queue as the
// stimulus is driven and popped when the DUT output is sampled 1 time unit
// after the rising edge. Follows HD63701_SLEEP_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_hd63701_phase_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mc_end;
    logic       mc_wai;
    logic       nmi;
    logic       irq;
    logic       imask;
    logic [5:0] phase;
    logic [1:0] vsel;
    logic       opc_ld;
    logic       int_ack;
    logic       halted;

    hd63701_phase_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mc_end  (mc_end),
        .mc_wai  (mc_wai),
        .nmi     (nmi),
        .irq     (irq),
        .imask   (imask),
        .phase   (phase),
        .vsel    (vsel),
        .opc_ld  (opc_ld),
        .int_ack (int_ack),
        .halted  (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] phase;
        logic [1:0] vsel;
        logic       opc;
        logic       ack;
        logic       halt;
    } exp_t;

    typedef struct packed {
        logic [5:0] stim;
        exp_t       want;
    } step_t;

    // Stimulus bits: {en, mc_end, mc_wai, nmi, irq, imask}
    localparam logic [5:0] S_OFF = 6'b000000;
    localparam logic [5:0] S_EN  = 6'b100000;
    localparam logic [5:0] S_END = 6'b010000;
    localparam logic [5:0] S_WAI = 6'b001000;
    localparam logic [5:0] S_NMI = 6'b000100;
    localparam logic [5:0] S_IRQ = 6'b000010;
    localparam logic [5:0] S_MSK = 6'b000001;

    step_t sq[$];
    exp_t  exp_q[$];
    exp_t  e;
    exp_t  got;
    int    pass_cnt  = 0;
    int    total_cnt = 0;

    function automatic step_t mk(input logic [5:0] s, input logic [5:0] ph,
                                 input logic [1:0] vs, input logic opc,
                                 input logic ack, input logic hlt);
        step_t r;
        r.stim = s;
        r.want = '{phase: ph, vsel: vs, opc: opc, ack: ack, halt: hlt};
        return r;
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("phase=%0d vsel=%0d opc_ld=%b int_ack=%b halted=%b",
                         x.phase, x.vsel, x.opc, x.ack, x.halt);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // INTR1..INTR9 followed by the VECT, VEC1, VEC2 vector fetch.
    task automatic add_intr_run(input logic [1:0] vs);
        for (int p = 33; p <= 41; p++) sq.push_back(mk(S_EN, 6'(p), vs, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd1, vs, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd2, vs, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd3, vs, 0, 0, 0));
    endtask

    task automatic add_fetch_exec(input logic [1:0] vs);
        sq.push_back(mk(S_EN, 6'd4, vs, 1, 0, 0));
        sq.push_back(mk(S_EN, 6'd16, vs, 0, 0, 0));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {en, mc_end, mc_wai, nmi, irq, imask} = S_EN;
        #2;
        got = {phase, vsel, opc_ld, int_ack, halted};
        total_cnt++;
        if (got !== exp_t'({6'd0, 2'd0, 1'b0, 1'b0, 1'b0}))
            $display("FAIL reset_async: got %s, expected phase=0 vsel=0 all strobes 0", fmt(got));
        else pass_cnt++;
        tick();
        tick();
        got = {phase, vsel, opc_ld, int_ack, halted};
        total_cnt++;
        if (got !== exp_t'({6'd0, 2'd0, 1'b0, 1'b0, 1'b0}))
            $display("FAIL reset_held: got %s, expected phase=0 vsel=0 all strobes 0", fmt(got));
        else pass_cnt++;
    endtask

    task automatic test_boot();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (phase !== 6'd0) $display("FAIL boot_release: phase=%0d expected 0", phase);
        else pass_cnt++;
        sq.push_back(mk(S_EN, 6'd1, 2'd0, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd2, 2'd0, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd3, 2'd0, 0, 0, 0));
        add_fetch_exec(2'd0);
        foreach (sq[i]) begin
            {en, mc_end, mc_wai, nmi, irq, imask} = sq[i].stim;
            exp_q.push_back(sq[i].want);
            tick();
            e   = exp_q.pop_front();
            got = {phase, vsel, opc_ld, int_ack, halted};
            total_cnt++;
            if (got !== e) $display("FAIL boot step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            else pass_cnt++;
        end
        sq.delete();
    endtask

    task automatic test_irq();
        sq.push_back(mk(S_EN, 6'd17, 2'd0, 0, 0, 0));
        // Masked IRQ at end of instruction: plain fetch.
        sq.push_back(mk(S_EN | S_END | S_IRQ | S_MSK, 6'd4, 2'd0, 1, 0, 0));
        sq.push_back(mk(S_EN, 6'd16, 2'd0, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd17, 2'd0, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd18, 2'd0, 0, 0, 0));
        sq.push_back(mk(S_EN | S_END | S_IRQ, 6'd32, 2'd2, 0, 1, 0));
        add_intr_run(2'd2);
        add_fetch_exec(2'd2);
        foreach (sq[i]) begin
            {en, mc_end, mc_wai, nmi, irq, imask} = sq[i].stim;
            exp_q.push_back(sq[i].want);
            tick();
            e   = exp_q.pop_front();
            got = {phase, vsel, opc_ld, int_ack, halted};
            total_cnt++;
            if (got !== e) $display("FAIL irq step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            else pass_cnt++;
        end
        sq.delete();
    endtask

    task automatic test_nmi_priority();
        sq.push_back(mk(S_EN | S_NMI, 6'd17, 2'd2, 0, 0, 0));
        sq.push_back(mk(S_EN | S_END | S_IRQ, 6'd32, 2'd1, 0, 1, 0));
        add_intr_run(2'd1);
        add_fetch_exec(2'd1);
        sq.push_back(mk(S_EN | S_END | S_IRQ, 6'd32, 2'd2, 0, 1, 0));
        add_intr_run(2'd2);
        add_fetch_exec(2'd2);
        foreach (sq[i]) begin
            {en, mc_end, mc_wai, nmi, irq, imask} = sq[i].stim;
            exp_q.push_back(sq[i].want);
            tick();
            e   = exp_q.pop_front();
            got = {phase, vsel, opc_ld, int_ack, halted};
            total_cnt++;
            if (got !== e) $display("FAIL nmi_priority step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            else pass_cnt++;
        end
        sq.delete();
    endtask

    task automatic test_en_hold();
        // NMI edge while disabled must still be captured.
        sq.push_back(mk(S_NMI, 6'd16, 2'd2, 0, 0, 0));
        sq.push_back(mk(S_OFF, 6'd16, 2'd2, 0, 0, 0));
        sq.push_back(mk(S_OFF, 6'd16, 2'd2, 0, 0, 0));
        sq.push_back(mk(S_EN | S_END, 6'd32, 2'd1, 0, 1, 0));
        add_intr_run(2'd1);
        sq.push_back(mk(S_EN, 6'd4, 2'd1, 1, 0, 0));
        sq.push_back(mk(S_OFF, 6'd4, 2'd1, 0, 0, 0));
        sq.push_back(mk(S_OFF, 6'd4, 2'd1, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd16, 2'd1, 0, 0, 0));
        foreach (sq[i]) begin
            {en, mc_end, mc_wai, nmi, irq, imask} = sq[i].stim;
            exp_q.push_back(sq[i].want);
            tick();
            e   = exp_q.pop_front();
            got = {phase, vsel, opc_ld, int_ack, halted};
            total_cnt++;
            if (got !== e) $display("FAIL en_hold step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            else pass_cnt++;
        end
        sq.delete();
    endtask

    task automatic test_nmi_collision();
        sq.push_back(mk(S_EN | S_NMI, 6'd17, 2'd1, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd18, 2'd1, 0, 0, 0));
        // Second NMI edge lands on the edge that accepts the first one.
        sq.push_back(mk(S_EN | S_END | S_NMI, 6'd32, 2'd1, 0, 1, 0));
        add_intr_run(2'd1);
        add_fetch_exec(2'd1);
        sq.push_back(mk(S_EN | S_END, 6'd32, 2'd1, 0, 1, 0));
        add_intr_run(2'd1);
        add_fetch_exec(2'd1);
        foreach (sq[i]) begin
            {en, mc_end, mc_wai, nmi, irq, imask} = sq[i].stim;
            exp_q.push_back(sq[i].want);
            tick();
            e   = exp_q.pop_front();
            got = {phase, vsel, opc_ld, int_ack, halted};
            total_cnt++;
            if (got !== e) $display("FAIL nmi_collision step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            else pass_cnt++;
        end
        sq.delete();
    endtask

    task automatic test_sleep();
`ifdef HD63701_SLEEP_EN
        sq.push_back(mk(S_EN | S_END | S_WAI, 6'd5, 2'd1, 0, 0, 0));
        for (int k = 0; k < 19; k++) sq.push_back(mk(S_EN, 6'd5, 2'd1, 0, 0, 0));
        sq.push_back(mk(S_EN | S_IRQ, 6'd32, 2'd2, 0, 1, 0));
        add_intr_run(2'd2);
        add_fetch_exec(2'd2);
        sq.push_back(mk(S_EN | S_END | S_WAI, 6'd5, 2'd2, 0, 0, 0));
        sq.push_back(mk(S_EN | S_NMI, 6'd5, 2'd2, 0, 0, 0));
        // NMI pending and IRQ both present: NMI vector wins.
        sq.push_back(mk(S_EN | S_IRQ, 6'd32, 2'd1, 0, 1, 0));
        add_intr_run(2'd1);
        add_fetch_exec(2'd1);
`else
        sq.push_back(mk(S_EN | S_END | S_WAI, 6'd4, 2'd1, 1, 0, 0));
        sq.push_back(mk(S_EN, 6'd16, 2'd1, 0, 0, 0));
`endif
        foreach (sq[i]) begin
            {en, mc_end, mc_wai, nmi, irq, imask} = sq[i].stim;
            exp_q.push_back(sq[i].want);
            tick();
            e   = exp_q.pop_front();
            got = {phase, vsel, opc_ld, int_ack, halted};
            total_cnt++;
            if (got !== e) $display("FAIL sleep step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            else pass_cnt++;
        end
        sq.delete();
    endtask

    task automatic test_halt();
        for (int p = 17; p <= 25; p++) sq.push_back(mk(S_EN, 6'(p), 2'd1, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd63, 2'd1, 0, 0, 1));
        sq.push_back(mk(S_EN | S_END | S_IRQ | S_NMI, 6'd63, 2'd1, 0, 0, 1));
        sq.push_back(mk(S_EN | S_END | S_IRQ, 6'd63, 2'd1, 0, 0, 1));
        sq.push_back(mk(S_EN, 6'd63, 2'd1, 0, 0, 1));
        foreach (sq[i]) begin
            {en, mc_end, mc_wai, nmi, irq, imask} = sq[i].stim;
            exp_q.push_back(sq[i].want);
            tick();
            e   = exp_q.pop_front();
            got = {phase, vsel, opc_ld, int_ack, halted};
            total_cnt++;
            if (got !== e) $display("FAIL halt step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            else pass_cnt++;
        end
        sq.delete();
        #2;
        rst_n = 1'b0;
        #1;
        got = {phase, vsel, opc_ld, int_ack, halted};
        total_cnt++;
        if (got !== exp_t'({6'd0, 2'd0, 1'b0, 1'b0, 1'b0}))
            $display("FAIL halt_reset: got %s, expected phase=0 vsel=0 halted=0", fmt(got));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        tick();
        rst_n = 1'b1;
        sq.push_back(mk(S_EN, 6'd1, 2'd0, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd2, 2'd0, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd3, 2'd0, 0, 0, 0));
        add_fetch_exec(2'd0);
        sq.push_back(mk(S_EN | S_END | S_IRQ, 6'd32, 2'd2, 0, 1, 0));
        for (int p = 33; p <= 36; p++) sq.push_back(mk(S_EN, 6'(p), 2'd2, 0, 0, 0));
        sq.push_back(mk(S_OFF, 6'd36, 2'd2, 0, 0, 0));
        foreach (sq[i]) begin
            {en, mc_end, mc_wai, nmi, irq, imask} = sq[i].stim;
            exp_q.push_back(sq[i].want);
            tick();
            e   = exp_q.pop_front();
            got = {phase, vsel, opc_ld, int_ack, halted};
            total_cnt++;
            if (got !== e) $display("FAIL reset_mid step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            else pass_cnt++;
        end
        sq.delete();
        // Reset pulse in the middle of INTR4 with the clock enable low.
        #2;
        rst_n = 1'b0;
        #1;
        got = {phase, vsel, opc_ld, int_ack, halted};
        total_cnt++;
        if (got !== exp_t'({6'd0, 2'd0, 1'b0, 1'b0, 1'b0}))
            $display("FAIL reset_mid_async: got %s, expected phase=0 vsel=0 all strobes 0", fmt(got));
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        sq.push_back(mk(S_OFF, 6'd0, 2'd0, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd1, 2'd0, 0, 0, 0));
        sq.push_back(mk(S_EN, 6'd2, 2'd0, 0, 0, 0));
        foreach (sq[i]) begin
            {en, mc_end, mc_wai, nmi, irq, imask} = sq[i].stim;
            exp_q.push_back(sq[i].want);
            tick();
            e   = exp_q.pop_front();
            got = {phase, vsel, opc_ld, int_ack, halted};
            total_cnt++;
            if (got !== e) $display("FAIL reset_mid_restart step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            else pass_cnt++;
        end
        sq.delete();
    endtask

    initial begin
        test_reset();
        test_boot();
        test_irq();
        test_nmi_priority();
        test_en_hold();
        test_nmi_collision();
        test_sleep();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hd63701_phase_seq.md
HD63701_PHASE_SEQ -- requirements
Module: hd63701_phase_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-002 CLK  in  1  core clock; all state changes on rising edge.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 EN  in  1  clock enable; state advances only on edges with EN=1.
REQ-005 MC_END  in  1  microcode end-of-instruction flag, valid in EXEC phases.
REQ-006 MC_WAI  in  1  microcode wait-for-interrupt request, qualified by MC_END.
REQ-007 NMI  in  1  non-maskable interrupt, rising-edge sensitive, synchronous to CLK.
REQ-008 IRQ  in  1  maskable interrupt, level sensitive.
REQ-009 IMASK  in  1  CCR I flag; 1 blocks IRQ.
REQ-010 PHASE  out  6  current phase code, drives microcode ROM phase select.
REQ-011 VSEL  out  2  vector select: 0 reset ($FFFE), 1 NMI ($FFFC), 2 IRQ ($FFF8).
REQ-012 OPC_LD  out  1  opcode-load strobe.
REQ-013 INT_ACK  out  1  interrupt-accept strobe.
REQ-014 HALTED  out  1  1 while in HALT.

Function
REQ-015 Phase codes SHALL be: RST=0, VECT=1, VEC1=2, VEC2=3, FETCH=4, SLEEP=5, EXEC0..EXEC9=16..25, INTR0..INTR9=32..41, HALT=63.
REQ-016 PHASE SHALL be registered; the code is visible the cycle after the transitioning EN edge.
REQ-017 Flow: RST->VECT->VEC1->VEC2->FETCH->EXEC0, one phase per enabled edge.
REQ-018 EXECn with MC_END=0 and n<9 -> EXEC(n+1); EXEC9 with MC_END=0 -> HALT.
REQ-019 EXECn with MC_END=1: nmi_pend -> INTR0 (VSEL=1); else IRQ & ~IMASK -> INTR0 (VSEL=2); else MC_WAI -> SLEEP; else FETCH.
REQ-020 INTR0..INTR8 advance sequentially; INTR9 -> VECT.
REQ-021 SLEEP holds until nmi_pend -> INTR0 (VSEL=1) or IRQ & ~IMASK -> INTR0 (VSEL=2); NMI wins when both are present.
REQ-022 HALT SHALL be left only by reset.
REQ-023 Rising NMI edge (NMI=1, previous sample 0, sampled every CLK regardless of EN) sets nmi_pend; nmi_pend clears on the enabled edge entering INTR0 with VSEL=1.
REQ-024 A new NMI edge in the same cycle as that clear SHALL leave nmi_pend set.
REQ-025 VSEL SHALL be updated only on entry to INTR0 and held constant through INTR0..VEC2.
REQ-026 OPC_LD SHALL be 1 exactly while PHASE=FETCH and EN=1.
REQ-027 INT_ACK SHALL be a one-cycle pulse registered on the edge entering INTR0.
REQ-028 With EN=0, all outputs hold; OPC_LD=0 and INT_ACK=0.

Reset
REQ-029 RST_N low SHALL force PHASE=RST, VSEL=0, OPC_LD=0, INT_ACK=0, HALTED=0, nmi_pend=0, NMI history=0, immediately and independent of CLK and EN.
REQ-030 Reset asserted mid-instruction or mid-interrupt SHALL abandon the sequence; the first enabled edge after release enters VECT with VSEL=0.

Configuration
REQ-031 Macro HD63701_SLEEP_EN: when defined, MC_WAI and the SLEEP phase behave per REQ-019/021.
REQ-032 Without HD63701_SLEEP_EN, MC_WAI SHALL be ignored, SLEEP is unreachable, and MC_END with no interrupt pending goes to FETCH.

Verification
REQ-033 Release RST_N, EN=1 -> PHASE 0,1,2,3,4,16 on successive cycles; VSEL=0; OPC_LD high one cycle at PHASE=4.
REQ-034 MC_END=1 at EXEC2, IRQ=1, IMASK=0 -> INT_ACK pulse, PHASE 32..41, then 1,2,3 with VSEL=2 throughout.
REQ-035 NMI pulse during EXEC0, MC_END at EXEC1 with IRQ=1 and IMASK=0 -> INTR0 with VSEL=1; after completion, second entry to INTR0 with VSEL=2.
REQ-036 MC_END never asserted -> PHASE reaches 25 then 63, HALTED=1; only RST_N low clears it.
REQ-037 HD63701_SLEEP_EN defined, MC_WAI=MC_END=1, no interrupt -> PHASE=5 held 20 cycles; IRQ=1 with IMASK=0 -> INTR0. Macro undefined, same stimulus -> PHASE=4.
REQ-038 RST_N pulsed low at INTR4 with EN=0 -> PHASE=0 immediately; after release, first enabled edge gives PHASE=1 with VSEL=0.
